// File: rtl/pi_fixed_pkg.sv
// Shared fixed-point helpers and FSM encoding for the time-multiplexed PI controller.
// Arithmetic is carried in a wide signed type so that every 2W+1-bit product fits without overflow.
package pi_fixed_pkg;

    localparam int unsigned WIDE     = 136;
    localparam int unsigned FRAC_DEF = 16;
    localparam logic [31:0] ONE      = 32'(1) << FRAC_DEF;

    typedef logic signed [WIDE-1:0] wide_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SUM,
        ST_MUL,
        ST_ACC,
        ST_WR
    } pi_state_t;

    function automatic wide_t sat_w(input wide_t v, input int unsigned w);
        wide_t hi;
        wide_t lo;
        wide_t r;
        hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo = -hi - wide_t'(1);
        if (v > hi)
            r = hi;
        else if (v < lo)
            r = lo;
        else
            r = v;
        return r;
    endfunction

    function automatic wide_t clamp_lim(input wide_t v, input wide_t lo, input wide_t hi);
        wide_t r;
        if (v > hi)
            r = hi;
        else if (v < lo)
            r = lo;
        else
            r = v;
        return r;
    endfunction

endpackage

// File: rtl/pi_channel_dp.sv
// Shared PI datapath for one channel slice: registered SUM, MUL and ACC stages,
// with the limited output and new integrator state presented for the WR cycle.
module pi_channel_dp
    import pi_fixed_pkg::*;
#(
    parameter int unsigned    W           = 32,
    parameter int unsigned    FRAC        = 16,
    parameter logic [W-1:0]   KP          = 32'h00008000,
    parameter logic [W-1:0]   KI_DT2      = 32'h00004000,
    parameter logic [W-1:0]   UPPER       = 32'h00018000,
    parameter logic [W-1:0]   LOWER       = 32'hFFFE8000,
    parameter bit             ANTI_WINDUP = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_sum,
    input  logic         en_mul,
    input  logic         en_acc,
    input  logic [W-1:0] xb,
    input  logic [W-1:0] xp,
    input  logic [W-1:0] i_cur,
    output logic [W-1:0] y,
    output logic         sat,
    output logic [W-1:0] i_new
);

    localparam wide_t KP_W = wide_t'($signed(KP));
    localparam wide_t KI_W = wide_t'($signed(KI_DT2));
    localparam wide_t UP_W = wide_t'($signed(UPPER));
    localparam wide_t LO_W = wide_t'($signed(LOWER));

    logic signed [W:0] s_q;
    logic [W-1:0]      pi_q;
    logic [W-1:0]      pp_q;
    logic [W-1:0]      in_q;
    logic [W-1:0]      u_q;
    logic signed [W:0] s_nx;
    wide_t             in_w;

    always_comb begin
        s_nx = {xb[W-1], xb} + {xp[W-1], xp};
        in_w = sat_w(wide_t'($signed(i_cur)) + wide_t'($signed(pi_q)), W);
        if (ANTI_WINDUP)
            in_w = clamp_lim(in_w, LO_W, UP_W);
    end

    // Arithmetic right shift on the signed wide product floors toward -inf.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_q  <= '0;
            pi_q <= '0;
            pp_q <= '0;
            in_q <= '0;
            u_q  <= '0;
        end else begin
            if (en_sum)
                s_q <= s_nx;
            if (en_mul) begin
                pi_q <= W'(sat_w((KI_W * wide_t'(s_q)) >>> FRAC, W));
                pp_q <= W'(sat_w((KP_W * wide_t'($signed(xb))) >>> FRAC, W));
            end
            if (en_acc) begin
                in_q <= W'(in_w);
                u_q  <= W'(sat_w(wide_t'($signed(pp_q)) + in_w, W));
            end
        end
    end

    always_comb begin
        y     = W'(clamp_lim(wide_t'($signed(u_q)), LO_W, UP_W));
        sat   = (y != u_q);
        i_new = in_q;
    end

endmodule

// File: rtl/pi_limit_multi.sv
// N-channel time-multiplexed PI controller with output limiting: FSM, channel
// counter, input buffer and per-channel integrator / previous-input state.
module pi_limit_multi
    import pi_fixed_pkg::*;
#(
    parameter int unsigned  N_CH        = 2,
    parameter int unsigned  W           = 32,
    parameter int unsigned  FRAC        = 16,
    parameter logic [W-1:0] KP          = 32'h00008000,
    parameter logic [W-1:0] KI_DT2      = 32'h00004000,
    parameter logic [W-1:0] UPPER       = 32'h00018000,
    parameter logic [W-1:0] LOWER       = 32'hFFFE8000,
    parameter bit           ANTI_WINDUP = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rst_user,
    input  logic              sta,
    input  logic [N_CH*W-1:0] x,
    output logic [N_CH*W-1:0] y,
    output logic [N_CH-1:0]   sat,
    output logic              busy,
    output logic              done_sig
);

    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    pi_state_t      state;
    pi_state_t      state_nx;
    logic [CH_W-1:0] ch;
    logic [W-1:0]   xb_q  [N_CH];
    logic [W-1:0]   i_st  [N_CH];
    logic [W-1:0]   xp_st [N_CH];
    logic [W-1:0]   y_q   [N_CH];

    logic           start;
    logic           en_sum;
    logic           en_mul;
    logic           en_acc;
    logic           wr;
    logic           last;
    logic [W-1:0]   y_ch;
    logic           sat_ch;
    logic [W-1:0]   i_new;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        en_sum   = 1'b0;
        en_mul   = 1'b0;
        en_acc   = 1'b0;
        wr       = 1'b0;
        last     = (ch == CH_W'(N_CH - 1));
        case (state)
            ST_IDLE: if (sta) begin
                start    = 1'b1;
                state_nx = ST_SUM;
            end
            ST_SUM: begin
                en_sum   = 1'b1;
                state_nx = ST_MUL;
            end
            ST_MUL: begin
                en_mul   = 1'b1;
                state_nx = ST_ACC;
            end
            ST_ACC: begin
                en_acc   = 1'b1;
                state_nx = ST_WR;
            end
            ST_WR: begin
                wr       = 1'b1;
                state_nx = last ? ST_IDLE : ST_SUM;
            end
            default: state_nx = ST_IDLE;
        endcase
        if (rst_user)
            state_nx = ST_IDLE;
    end

    // rst_user wins over start and write-back in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ch       <= '0;
            busy     <= 1'b0;
            done_sig <= 1'b0;
            sat      <= '0;
            for (int unsigned k = 0; k < N_CH; k++) begin
                xb_q[k]  <= '0;
                i_st[k]  <= '0;
                xp_st[k] <= '0;
                y_q[k]   <= '0;
            end
        end else if (rst_user) begin
            ch       <= '0;
            busy     <= 1'b0;
            done_sig <= 1'b0;
            sat      <= '0;
            for (int unsigned k = 0; k < N_CH; k++) begin
                i_st[k]  <= '0;
                xp_st[k] <= '0;
                y_q[k]   <= '0;
            end
        end else begin
            done_sig <= 1'b0;
            if (start) begin
                busy <= 1'b1;
                ch   <= '0;
                for (int unsigned k = 0; k < N_CH; k++)
                    xb_q[k] <= x[k*W +: W];
            end
            if (wr) begin
                y_q[ch]   <= y_ch;
                sat[ch]   <= sat_ch;
                i_st[ch]  <= i_new;
                xp_st[ch] <= xb_q[ch];
                if (last) begin
                    busy     <= 1'b0;
                    done_sig <= 1'b1;
                end else begin
                    ch <= ch + 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < N_CH; k++)
            y[k*W +: W] = y_q[k];
    end

    pi_channel_dp #(
        .W          (W),
        .FRAC       (FRAC),
        .KP         (KP),
        .KI_DT2     (KI_DT2),
        .UPPER      (UPPER),
        .LOWER      (LOWER),
        .ANTI_WINDUP(ANTI_WINDUP)
    ) u_dp (
        .clk   (clk),
        .rst   (rst),
        .en_sum(en_sum),
        .en_mul(en_mul),
        .en_acc(en_acc),
        .xb    (xb_q[ch]),
        .xp    (xp_st[ch]),
        .i_cur (i_st[ch]),
        .y     (y_ch),
        .sat   (sat_ch),
        .i_new (i_new)
    );

endmodule

// File: tb/tb_pi_limit_multi.sv
// Directed bench for pi_limit_multi: integration, anti-windup on/off, sta while
// busy, rst_user mid-step, floor rounding, arithmetic saturation and async reset.
module tb_pi_limit_multi;

    logic        clk;
    logic        rst;
    logic        rst_user;
    logic        sta;
    logic [63:0] x;
    logic [63:0] y_a, y_b;
    logic [1:0]  sat_a, sat_b;
    logic        busy_a, busy_b, done_a, done_b;

    logic        rst_user_c;
    logic        sta_c;
    logic [63:0] x_c;
    logic [63:0] y_c;
    logic [1:0]  sat_c;
    logic        busy_c, done_c;

    int checks   = 0;
    int failures = 0;

    localparam logic [63:0] X_ONES = {32'h00010000, 32'h00010000};

    pi_limit_multi dut_a (
        .clk(clk), .rst(rst), .rst_user(rst_user), .sta(sta), .x(x),
        .y(y_a), .sat(sat_a), .busy(busy_a), .done_sig(done_a)
    );

    pi_limit_multi #(.ANTI_WINDUP(1'b0)) dut_b (
        .clk(clk), .rst(rst), .rst_user(rst_user), .sta(sta), .x(x),
        .y(y_b), .sat(sat_b), .busy(busy_b), .done_sig(done_b)
    );

    pi_limit_multi #(.KP(32'h00020000)) dut_c (
        .clk(clk), .rst(rst), .rst_user(rst_user_c), .sta(sta_c), .x(x_c),
        .y(y_c), .sat(sat_c), .busy(busy_c), .done_sig(done_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts a step (cycle 0), then observes a bounded 14-cycle window.
    task automatic run_step(input bit use_c, input logic [63:0] xv, input int extra, input int ru_at,
                            output int done_at, output int done_cnt, output int busy_cnt,
                            output int busy_last);
        logic d, b;
        @(negedge clk);
        if (use_c) begin sta_c = 1'b1; x_c = xv; end
        else       begin sta   = 1'b1; x   = xv; end
        done_at = 0; done_cnt = 0; busy_cnt = 0; busy_last = 0;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            sta = 1'b0; sta_c = 1'b0; rst_user = 1'b0;
            x = ~xv; x_c = ~xv;
            if (n == extra) begin
                if (use_c) sta_c = 1'b1; else sta = 1'b1;
            end
            if (n == ru_at) rst_user = 1'b1;
            d = use_c ? done_c : done_a;
            b = use_c ? busy_c : busy_a;
            if (d) begin
                if (done_cnt == 0) done_at = n;
                done_cnt++;
            end
            if (b) begin
                busy_cnt++;
                busy_last = n;
            end
        end
    endtask

    task automatic check_timing(input string tag, input int done_at, input int done_cnt,
                                input int busy_cnt, input int busy_last);
        check({tag, "_done_at"},   64'(done_at),   64'd9);
        check({tag, "_done_cnt"},  64'(done_cnt),  64'd1);
        check({tag, "_busy_cnt"},  64'(busy_cnt),  64'd8);
        check({tag, "_busy_last"}, 64'(busy_last), 64'd8);
    endtask

    initial begin
        int da, dc, bc, bl;
        rst = 1'b0; rst_user = 1'b0; sta = 1'b0; x = '0;
        rst_user_c = 1'b0; sta_c = 1'b0; x_c = '0;
        repeat (3) @(negedge clk);
        check("rst_y",    y_a,             64'h0);
        check("rst_sat",  64'(sat_a),      64'h0);
        check("rst_busy", 64'(busy_a),     64'h0);
        check("rst_done", 64'(done_a),     64'h0);
        rst = 1'b1;

        // Integration over three steps
        run_step(1'b0, X_ONES, 0, 0, da, dc, bc, bl);
        check_timing("s1", da, dc, bc, bl);
        check("s1_y0",   64'(y_a[31:0]),  64'h0000C000);
        check("s1_y1",   64'(y_a[63:32]), 64'h0000C000);
        check("s1_sat",  64'(sat_a),      64'h0);
        check("s1_b_y0", 64'(y_b[31:0]),  64'h0000C000);
        run_step(1'b0, X_ONES, 0, 0, da, dc, bc, bl);
        check_timing("s2", da, dc, bc, bl);
        check("s2_y0",   64'(y_a[31:0]),  64'h00014000);
        check("s2_sat0", 64'(sat_a[0]),   64'h0);
        run_step(1'b0, X_ONES, 0, 0, da, dc, bc, bl);
        check("s3_y0",   64'(y_a[31:0]),  64'h00018000);
        check("s3_sat0", 64'(sat_a[0]),   64'h1);
        check("s3_b_y0", 64'(y_b[31:0]),  64'h00018000);

        // Step 4 saturates; step 5 with x0=-1.0 exposes integrator windup (or not)
        run_step(1'b0, X_ONES, 0, 0, da, dc, bc, bl);
        check("s4_y0",     64'(y_a[31:0]), 64'h00018000);
        check("s4_sat0",   64'(sat_a[0]),  64'h1);
        check("s4_b_y0",   64'(y_b[31:0]), 64'h00018000);
        check("s4_b_sat0", 64'(sat_b[0]),  64'h1);
        run_step(1'b0, {32'h00010000, 32'hFFFF0000}, 0, 0, da, dc, bc, bl);
        check("s5_aw_y0",   64'(y_a[31:0]),  64'h00010000);
        check("s5_aw_sat0", 64'(sat_a[0]),   64'h0);
        check("s5_aw_y1",   64'(y_a[63:32]), 64'h00018000);
        check("s5_aw_sat1", 64'(sat_a[1]),   64'h1);
        check("s5_naw_y0",  64'(y_b[31:0]),  64'h00014000);
        check("s5_naw_sat0",64'(sat_b[0]),   64'h0);

        // sta again at cycle 3 is ignored
        run_step(1'b0, X_ONES, 3, 0, da, dc, bc, bl);
        check_timing("busy_sta", da, dc, bc, bl);

        // rst_user at cycle 5 aborts the step
        run_step(1'b0, X_ONES, 0, 5, da, dc, bc, bl);
        check("ru_done_cnt", 64'(dc),     64'd0);
        check("ru_busy_cnt", 64'(bc),     64'd5);
        check("ru_y",        y_a,         64'h0);
        check("ru_sat",      64'(sat_a),  64'h0);
        check("ru_busy",     64'(busy_a), 64'h0);
        run_step(1'b0, X_ONES, 0, 0, da, dc, bc, bl);
        check_timing("ru_next", da, dc, bc, bl);
        check("ru_next_y0",  64'(y_a[31:0]), 64'h0000C000);
        check("ru_next_sat", 64'(sat_a),     64'h0);

        // Idle rst_user, then a -1 LSB input: floor shifts give pp=pi=-1 LSB
        @(negedge clk); rst_user = 1'b1;
        @(negedge clk); rst_user = 1'b0;
        check("idle_ru_y", y_a, 64'h0);
        run_step(1'b0, {32'h0, 32'hFFFFFFFF}, 0, 0, da, dc, bc, bl);
        check("floor_y0",   64'(y_a[31:0]),  64'hFFFFFFFE);
        check("floor_y1",   64'(y_a[63:32]), 64'h0);
        check("floor_b_y0", 64'(y_b[31:0]),  64'hFFFFFFFE);

        // Proportional product saturation with KP = 2.0
        run_step(1'b1, {32'h0, 32'h7FFF0000}, 0, 0, da, dc, bc, bl);
        check_timing("psat", da, dc, bc, bl);
        check("psat_y0",   64'(y_c[31:0]),  64'h00018000);
        check("psat_sat0", 64'(sat_c[0]),   64'h1);
        check("psat_y1",   64'(y_c[63:32]), 64'h0);

        // Async reset mid-step clears outputs without waiting for a clock edge
        @(negedge clk); sta_c = 1'b1;
        @(negedge clk); sta_c = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_arst_busy", 64'(busy_c), 64'h1);
        rst = 1'b0;
        #1;
        check("arst_y_c",    y_c,         64'h0);
        check("arst_sat_c",  64'(sat_c),  64'h0);
        check("arst_busy_c", 64'(busy_c), 64'h0);
        check("arst_y_a",    y_a,         64'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
